otter_trap_ctrl: RTL and testbench
==================================

Name: otter_trap_ctrl

Overview:
- Trap/interrupt sequencer for the Otter machine-mode CSR file.
- Watches decoded system instructions and the CSR's pending-interrupt flag, then drives the CSR `op`/`pc_addr` inputs for one cycle.
- Stalls the fetch/decode pipeline and issues a PC redirect to `mtvec` (trap entry) or `mepc` (MRET).
- Handles WFI sleep with an optional cycle-bounded timeout.

Parameters:
- WFI_TIMEOUT, 0: cycles to sleep in WFI before resuming at pc+4 without an interrupt; 0 = wait forever.
- CNT_W, 16: width of the WFI cycle counter; WFI_TIMEOUT must be < 2^CNT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- instr_vld  in  1  decode stage holds a valid instruction this cycle.
- pc  in  32  PC of the decode-stage instruction.
- dec_ecall  in  1  instruction is ECALL.
- dec_ebreak  in  1  instruction is EBREAK.
- dec_mret  in  1  instruction is MRET.
- dec_wfi  in  1  instruction is WFI.
- dec_illegal  in  1  illegal instruction, including CSR write to a read_only or !addr_vld address.
- intrpt_vld  in  1  from CSR: MIE set and an enabled interrupt is pending.
- mtvec  in  32  from CSR.
- mepc  in  32  from CSR.
- csr_op  out  3  CSR op, using the CSR_OP_* encodings in otter_defines.vh.
- csr_pc  out  32  value for CSR `pc_addr`.
- stall  out  1  freeze fetch/decode.
- redirect  out  1  one-cycle pulse: load redirect_pc into the PC.
- redirect_pc  out  32  target PC.
- sleeping  out  1  in WFI wait.

Behaviour:
- Reset values:
  - state = IDLE; csr_op = CSR_OP_WFI (CSR no-op).
  - csr_pc = 0, stall = 0, redirect = 0, redirect_pc = 0, sleeping = 0, wfi counter = 0.
  - Reset mid-sequence aborts it in the next cycle; no redirect is issued.
- States: IDLE, REDIR, WAIT.
- Event selection in IDLE, only when instr_vld = 1. Fixed priority:
  - intrpt_vld → CSR_OP_INTRPT
  - dec_illegal → CSR_OP_TRAP
  - dec_ecall → CSR_OP_ECALL
  - dec_ebreak → CSR_OP_EBREAK
  - dec_mret → CSR_OP_MRET
  - dec_wfi → CSR_OP_WFI (sleep entry)
  - When instr_vld = 0, intrpt_vld is ignored.
- Trap/MRET acceptance (cycle N):
  - csr_op is driven combinationally, so the CSR updates on edge N.
  - csr_pc = pc; stall = 1 combinationally.
  - Latch target kind; next state = REDIR.
- REDIR (cycle N+1):
  - stall = 1, redirect = 1.
  - redirect_pc = {mtvec[31:2], 2'b00} for traps and interrupts.
  - redirect_pc = mepc for MRET (mepc is unaffected by MRET, so the current value is used).
  - Next state = IDLE. Total latency: 2 cycles, exactly one redirect pulse.
- WFI:
  - Cycle N: stall = 1, csr_op = CSR_OP_WFI, latch pc, clear counter; next state = WAIT.
  - WAIT: stall = 1, sleeping = 1, counter increments and saturates at 2^CNT_W−1.
  - WAIT exit on intrpt_vld: in the same cycle drive csr_op = CSR_OP_INTRPT with csr_pc = latched pc+4 (the WFI has retired); next state = REDIR (trap target).
  - WAIT exit on timeout (WFI_TIMEOUT ≠ 0 and counter == WFI_TIMEOUT−1): next cycle redirect = 1, redirect_pc = latched pc+4, state = IDLE; no CSR op is issued.
  - Interrupt and timeout in the same cycle: the interrupt wins.
- No event in IDLE: csr_op = CSR_OP_WFI, stall = 0, redirect = 0.
- pc+4 wraps modulo 2^32.
- No new event is accepted in REDIR/WAIT. Decode inputs are ignored there, because the stall holds decode.

Optional Feature:
- OTTER_TRAP_VECTORED_EN
- Defined:
  - When mtvec[1:0] == 2'b01 and the event is an interrupt, redirect_pc = {mtvec[31:2],2'b00} + 4*11 (machine external interrupt cause 11).
  - Synchronous exceptions always go to the base address.
  - mtvec[1:0] ∈ {2,3} is treated as direct mode.
- Undefined: direct mode only; mtvec[1:0] is ignored.

Test Plan:
- ECALL at pc=0x100, mtvec=0x200:
  - Cycle N: csr_op=ECALL, csr_pc=0x100, stall=1.
  - N+1: redirect=1, redirect_pc=0x200.
  - N+2: stall=0.
- MRET with mepc=0x104: csr_op=MRET at N; redirect_pc=0x104 at N+1.
- intrpt_vld together with dec_ecall at pc=0x40: csr_op=INTRPT (not ECALL), csr_pc=0x40, then redirect to mtvec base.
- WFI at pc=0x80, WFI_TIMEOUT=0, intrpt_vld asserted 10 cycles later:
  - sleeping=1 throughout; stall held.
  - csr_op=INTRPT with csr_pc=0x84; redirect to mtvec next cycle.
- WFI_TIMEOUT=5, no interrupt: redirect to pc+4 exactly 5 cycles after entering WAIT, plus one redirect cycle; csr_op stays WFI throughout.
- With OTTER_TRAP_VECTORED_EN, mtvec=0x301, interrupt → redirect_pc=0x32C; ECALL with the same mtvec → 0x300.
- rst asserted in REDIR: redirect stays 0, all outputs at reset values next cycle.

Source files
------------

// File: rtl/otter_trap_ctrl.sv
// otter_trap_ctrl: trap/interrupt sequencer for the Otter machine-mode CSR file.
// Accepts ECALL/EBREAK/illegal/MRET/WFI and pending interrupts from decode,
// drives the CSR op for one cycle, stalls fetch/decode, then redirects the PC.
// WFI sleeps until an interrupt or, if WFI_TIMEOUT != 0, a cycle-bounded timeout.
// Optional: define OTTER_TRAP_VECTORED_EN for vectored interrupt entry
// (mtvec[1:0] == 2'b01 sends interrupts to base + 4*11).
// csr_op/csr_pc/stall must reach the CSR in the accepting cycle, so outputs are
// decoded from the registered state; all outputs are held at reset values while
// rst is high so a sequence cut short by reset never emits a redirect.
module otter_trap_ctrl #(
  parameter int unsigned WFI_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_vld,
  input  logic [31:0] pc,
  input  logic        dec_ecall,
  input  logic        dec_ebreak,
  input  logic        dec_mret,
  input  logic        dec_wfi,
  input  logic        dec_illegal,
  input  logic        intrpt_vld,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [2:0]  csr_op,
  output logic [31:0] csr_pc,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        sleeping
);

  // CSR op encodings, kept in step with otter_defines.vh
  localparam logic [2:0] CSR_OP_WFI    = 3'd0;
  localparam logic [2:0] CSR_OP_INTRPT = 3'd1;
  localparam logic [2:0] CSR_OP_TRAP   = 3'd2;
  localparam logic [2:0] CSR_OP_ECALL  = 3'd3;
  localparam logic [2:0] CSR_OP_EBREAK = 3'd4;
  localparam logic [2:0] CSR_OP_MRET   = 3'd5;

  localparam logic [CNT_W-1:0] TO_LAST =
    (WFI_TIMEOUT == 0) ? '0 : CNT_W'(WFI_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REDIR, WAIT} state_t;
  typedef enum logic [1:0] {TGT_TRAP, TGT_INTR, TGT_MRET, TGT_RESUME} tgt_t;

  state_t           state;
  tgt_t             tgt;
  logic [31:0]      wfi_pc;
  logic [CNT_W-1:0] wfi_cnt;

  logic        ev_take;
  logic        ev_wfi;
  logic [2:0]  ev_op;
  tgt_t        ev_tgt;
  logic        timeout_hit;
  logic [31:0] wfi_pc_next;
  logic [31:0] trap_target;

  assign wfi_pc_next = wfi_pc + 32'd4;
  assign timeout_hit = (WFI_TIMEOUT != 0) && (wfi_cnt == TO_LAST);

  // Fixed-priority event selection from the decode stage
  always_comb begin
    ev_take = 1'b0;
    ev_wfi  = 1'b0;
    ev_op   = CSR_OP_WFI;
    ev_tgt  = TGT_TRAP;
    if (instr_vld) begin
      if (intrpt_vld) begin
        ev_take = 1'b1; ev_op = CSR_OP_INTRPT; ev_tgt = TGT_INTR;
      end else if (dec_illegal) begin
        ev_take = 1'b1; ev_op = CSR_OP_TRAP;
      end else if (dec_ecall) begin
        ev_take = 1'b1; ev_op = CSR_OP_ECALL;
      end else if (dec_ebreak) begin
        ev_take = 1'b1; ev_op = CSR_OP_EBREAK;
      end else if (dec_mret) begin
        ev_take = 1'b1; ev_op = CSR_OP_MRET; ev_tgt = TGT_MRET;
      end else if (dec_wfi) begin
        ev_take = 1'b1; ev_wfi = 1'b1;
      end
    end
  end

  // Trap entry address from mtvec (direct, or vectored for interrupts)
  always_comb begin
    trap_target = mtvec & ~32'h3;
`ifdef OTTER_TRAP_VECTORED_EN
    if (tgt == TGT_INTR && mtvec[1:0] == 2'b01)
      trap_target = (mtvec & ~32'h3) + 32'd44;
`endif
  end

  // Sequencer state, latched target kind, WFI pc and sleep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tgt     <= TGT_TRAP;
      wfi_pc  <= '0;
      wfi_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_take) begin
            if (ev_wfi) begin
              state   <= WAIT;
              wfi_pc  <= pc;
              wfi_cnt <= '0;
            end else begin
              state <= REDIR;
              tgt   <= ev_tgt;
            end
          end
        end
        WAIT: begin
          if (intrpt_vld) begin
            state <= REDIR;
            tgt   <= TGT_INTR;
          end else if (timeout_hit) begin
            state <= REDIR;
            tgt   <= TGT_RESUME;
          end else if (wfi_cnt != '1) begin
            wfi_cnt <= wfi_cnt + 1'b1;
          end
        end
        REDIR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode for the current state
  always_comb begin
    csr_op      = CSR_OP_WFI;
    csr_pc      = '0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    sleeping    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (ev_take) begin
            csr_op = ev_op;
            csr_pc = pc;
            stall  = 1'b1;
          end
        end
        WAIT: begin
          stall    = 1'b1;
          sleeping = 1'b1;
          if (intrpt_vld) begin
            csr_op = CSR_OP_INTRPT;
            csr_pc = wfi_pc_next;
          end
        end
        REDIR: begin
          stall    = 1'b1;
          redirect = 1'b1;
          case (tgt)
            TGT_MRET:   redirect_pc = mepc;
            TGT_RESUME: redirect_pc = wfi_pc_next;
            default:    redirect_pc = trap_target;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_trap_ctrl.sv
// tb_otter_trap_ctrl: table-driven checks of trap/MRET entry plus hand-written
// WFI, timeout, reset-abort and vectored-entry sequences. Two instances share
// stimulus: u0 sleeps forever in WFI, u5 has WFI_TIMEOUT = 5.
module tb_otter_trap_ctrl;

  localparam logic [2:0] OP_WFI    = 3'd0;
  localparam logic [2:0] OP_INTRPT = 3'd1;
  localparam logic [2:0] OP_TRAP   = 3'd2;
  localparam logic [2:0] OP_ECALL  = 3'd3;
  localparam logic [2:0] OP_EBREAK = 3'd4;
  localparam logic [2:0] OP_MRET   = 3'd5;

  logic clk = 1'b0;
  logic rst;
  logic instr_vld, dec_ecall, dec_ebreak, dec_mret, dec_wfi, dec_illegal, intrpt_vld;
  logic [31:0] pc, mtvec, mepc;

  logic [2:0]  op0, op5;
  logic [31:0] cpc0, cpc5, rpc0, rpc5;
  logic        stall0, stall5, redir0, redir5, sleep0, sleep5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  otter_trap_ctrl #(.WFI_TIMEOUT(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .instr_vld(instr_vld), .pc(pc),
    .dec_ecall(dec_ecall), .dec_ebreak(dec_ebreak), .dec_mret(dec_mret),
    .dec_wfi(dec_wfi), .dec_illegal(dec_illegal), .intrpt_vld(intrpt_vld),
    .mtvec(mtvec), .mepc(mepc), .csr_op(op0), .csr_pc(cpc0), .stall(stall0),
    .redirect(redir0), .redirect_pc(rpc0), .sleeping(sleep0)
  );

  otter_trap_ctrl #(.WFI_TIMEOUT(5), .CNT_W(16)) u5 (
    .clk(clk), .rst(rst), .instr_vld(instr_vld), .pc(pc),
    .dec_ecall(dec_ecall), .dec_ebreak(dec_ebreak), .dec_mret(dec_mret),
    .dec_wfi(dec_wfi), .dec_illegal(dec_illegal), .intrpt_vld(intrpt_vld),
    .mtvec(mtvec), .mepc(mepc), .csr_op(op5), .csr_pc(cpc5), .stall(stall5),
    .redirect(redir5), .redirect_pc(rpc5), .sleeping(sleep5)
  );

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic        intr, ill, ecall, ebreak, mret, wfi;
    logic [31:0] mtvec, mepc;
    logic [2:0]  op;
    logic [31:0] cpc;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    instr_vld = 0; dec_ecall = 0; dec_ebreak = 0; dec_mret = 0;
    dec_wfi = 0; dec_illegal = 0; intrpt_vld = 0; pc = '0;
  endtask

  task automatic do_reset();
    clear_dec();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // WFI on u0 (no timeout), interrupt after `wait_cycles` sleeping cycles
  task automatic wfi_intr_u0(input logic [31:0] wpc, input int unsigned wait_cycles);
    do_reset();
    mtvec = 32'h200;
    instr_vld = 1; dec_wfi = 1; pc = wpc;
    @(negedge clk);
    chk("wfi_entry_op", op0, OP_WFI);
    chk("wfi_entry_stall", stall0, 1);
    tick();
    clear_dec();
    for (int unsigned k = 0; k < wait_cycles; k++) begin
      @(negedge clk);
      chk("wfi_sleep", sleep0, 1);
      chk("wfi_sleep_stall", stall0, 1);
      chk("wfi_sleep_redir", redir0, 0);
      chk("wfi_sleep_op", op0, OP_WFI);
      tick();
    end
    intrpt_vld = 1;
    @(negedge clk);
    chk("wfi_wake_op", op0, OP_INTRPT);
    chk("wfi_wake_cpc", cpc0, wpc + 32'd4);
    chk("wfi_wake_sleep", sleep0, 1);
    tick();
    intrpt_vld = 0;
    @(negedge clk);
    chk("wfi_wake_redir", redir0, 1);
    chk("wfi_wake_rpc", rpc0, 32'h200);
    chk("wfi_wake_sleep_off", sleep0, 0);
    tick();
    @(negedge clk);
    chk("wfi_wake_done_stall", stall0, 0);
  endtask

  // WFI on u5 (timeout 5); optional interrupt in the last sleeping cycle
  task automatic wfi_timeout_u5(input logic [31:0] wpc, input logic intr_last);
    do_reset();
    mtvec = 32'h400;
    instr_vld = 1; dec_wfi = 1; pc = wpc;
    @(negedge clk);
    chk("to_entry_op", op5, OP_WFI);
    chk("to_entry_stall", stall5, 1);
    tick();
    clear_dec();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) intrpt_vld = intr_last;
      @(negedge clk);
      chk("to_sleep", sleep5, 1);
      chk("to_sleep_redir", redir5, 0);
      chk("to_sleep_op", op5, (k == 4 && intr_last) ? OP_INTRPT : OP_WFI);
      tick();
    end
    intrpt_vld = 0;
    @(negedge clk);
    chk("to_redir", redir5, 1);
    chk("to_rpc", rpc5, intr_last ? 32'h400 : wpc + 32'd4);
    chk("to_redir_op", op5, OP_WFI);
    chk("to_redir_sleep", sleep5, 0);
    tick();
    @(negedge clk);
    chk("to_done_stall", stall5, 0);
    chk("to_done_redir", redir5, 0);
  endtask

  initial begin
    mtvec = '0; mepc = '0;
    vecs[0] = '{1'b1, 32'h100, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 32'h200, 32'h0,   OP_ECALL,  32'h100, 1'b1, 32'h200};
    vecs[1] = '{1'b1, 32'h050, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 32'h200, 32'h104, OP_MRET,   32'h050, 1'b1, 32'h104};
    vecs[2] = '{1'b1, 32'h040, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 32'h200, 32'h0,   OP_INTRPT, 32'h040, 1'b1, 32'h200};
    vecs[3] = '{1'b1, 32'h044, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 32'h203, 32'h0,   OP_TRAP,   32'h044, 1'b1, 32'h200};
    vecs[4] = '{1'b1, 32'h048, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 32'h1000,32'h88,  OP_EBREAK, 32'h048, 1'b1, 32'h1000};
    vecs[5] = '{1'b0, 32'h04C, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 32'h200, 32'h0,   OP_WFI,    32'h0,   1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h060, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'h202, 32'h0,   OP_INTRPT, 32'h060, 1'b1, 32'h200};
    vecs[7] = '{1'b1, 32'h070, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 32'h200, 32'h5A4, OP_MRET,   32'h070, 1'b1, 32'h5A4};
    vecs[8] = '{1'b1, 32'h074, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 32'h301, 32'h0,   OP_ECALL,  32'h074, 1'b1, 32'h300};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_op", op0, OP_WFI);
    chk("rst_cpc", cpc0, 0);
    chk("rst_stall", stall0, 0);
    chk("rst_redir", redir0, 0);
    chk("rst_rpc", rpc0, 0);
    chk("rst_sleep", sleep0, 0);

    // Single-instruction events: cycle N, N+1 redirect, N+2 released
    for (int i = 0; i < 9; i++) begin
      do_reset();
      mtvec = vecs[i].mtvec; mepc = vecs[i].mepc;
      instr_vld = vecs[i].vld; pc = vecs[i].pc; intrpt_vld = vecs[i].intr;
      dec_illegal = vecs[i].ill; dec_ecall = vecs[i].ecall; dec_ebreak = vecs[i].ebreak;
      dec_mret = vecs[i].mret; dec_wfi = vecs[i].wfi;
      @(negedge clk);
      chk($sformatf("v%0d_op", i), op0, vecs[i].op);
      chk($sformatf("v%0d_cpc", i), cpc0, vecs[i].cpc);
      chk($sformatf("v%0d_stall", i), stall0, vecs[i].redir);
      tick();
      clear_dec();
      @(negedge clk);
      chk($sformatf("v%0d_redir", i), redir0, vecs[i].redir);
      chk($sformatf("v%0d_rpc", i), rpc0, vecs[i].rpc);
      chk($sformatf("v%0d_redir_stall", i), stall0, vecs[i].redir);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_done_stall", i), stall0, 0);
      chk($sformatf("v%0d_done_redir", i), redir0, 0);
    end

    // WFI sleeps until interrupt, resumes via trap with csr_pc = pc+4
    wfi_intr_u0(32'h80, 10);
    // WFI timeout resumes at pc+4, including wrap at the top of memory
    wfi_timeout_u5(32'h80, 1'b0);
    wfi_timeout_u5(32'hFFFF_FFFC, 1'b0);
    // Interrupt coinciding with the timeout cycle wins
    wfi_timeout_u5(32'h90, 1'b1);

    // Reset asserted in REDIR suppresses the redirect
    do_reset();
    mtvec = 32'h200;
    instr_vld = 1; dec_ecall = 1; pc = 32'h100;
    tick();
    clear_dec();
    rst = 1;
    @(negedge clk);
    chk("rstredir_redir", redir0, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("rstredir_after_redir", redir0, 0);
    chk("rstredir_after_stall", stall0, 0);
    chk("rstredir_after_rpc", rpc0, 0);
    chk("rstredir_after_op", op0, OP_WFI);

    // Reset asserted in WAIT wakes the core without a redirect
    do_reset();
    instr_vld = 1; dec_wfi = 1; pc = 32'h80;
    tick();
    clear_dec();
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rstwait_sleep", sleep0, 0);
    chk("rstwait_stall", stall0, 0);
    chk("rstwait_redir", redir0, 0);

    // Interrupt with mtvec mode 01
    do_reset();
    mtvec = 32'h301;
    instr_vld = 1; intrpt_vld = 1; pc = 32'h10;
    @(negedge clk);
    chk("vec_op", op0, OP_INTRPT);
    tick();
    clear_dec();
    @(negedge clk);
    chk("vec_redir", redir0, 1);
`ifdef OTTER_TRAP_VECTORED_EN
    chk("vec_rpc", rpc0, 32'h32C);
`else
    chk("vec_rpc", rpc0, 32'h300);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
